// File: rtl/arbitro_contador.sv
// Round-robin scheduler sharing one up/down counter among N_REQ edge-triggered requesters.
// One captured event is granted per cycle; the winner steps the counter by +/-1.
module arbitro_contador #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] dir_i,
  output logic [WIDTH-1:0] conta_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] pend_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  logic [N_REQ-1:0] r_req_q;
  logic [N_REQ-1:0] r_pend;
  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_ovf;
  logic             r_udf;

  logic [N_REQ-1:0] w_evt;
  logic             w_found;
  logic [PW-1:0]    w_idx;
  logic             w_grant;
  logic [N_REQ-1:0] w_gnt_vec;
  logic             w_dir;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_ovf_evt;
  logic             w_udf_evt;

  assign w_evt = req_i & ~r_req_q;

  // First pending requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin : search
    int j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(r_ptr) + i) % N_REQ;
      if (!w_found && r_pend[j]) begin
        w_found = 1'b1;
        w_idx   = PW'(j);
      end
    end
  end

  assign w_grant   = en_i & ~clr_i & w_found;
  assign w_gnt_vec = w_grant ? (N_REQ'(1) << w_idx) : '0;
  assign w_dir     = dir_i[w_idx];
  assign w_cnt_nxt = w_dir ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
  assign w_ovf_evt = w_dir && (r_cnt == '1);
  assign w_udf_evt = !w_dir && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_req_q <= '1;
      r_pend  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_req_q <= req_i;
      // A new event on the granted requester survives the grant clear.
      r_pend  <= (r_pend & ~w_gnt_vec) | w_evt;
      if (clr_i) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
        r_gnt <= '0;
      end else if (w_grant) begin
        r_gnt <= w_gnt_vec;
        r_cnt <= w_cnt_nxt;
        r_ovf <= r_ovf | w_ovf_evt;
        r_udf <= r_udf | w_udf_evt;
        r_ptr <= (w_idx == LAST) ? '0 : (w_idx + PW'(1));
      end else begin
        r_gnt <= '0;
      end
    end
  end

  assign conta_o = r_cnt;
  assign gnt_o   = r_gnt;
  assign pend_o  = r_pend;
  assign busy_o  = |r_pend;
  assign ovf_o   = r_ovf;
  assign udf_o   = r_udf;

endmodule

// File: tb/tb_arbitro_contador.sv
// Scoreboard bench for arbitro_contador: stimulus queues expected grants,
// a negedge monitor pops them whenever gnt_o is non-zero.
module tb_arbitro_contador;

  logic       clk = 1'b0;
  logic       rst_i, en_i, clr_i;
  logic [3:0] req_i, dir_i;
  logic [7:0] conta_o;
  logic [3:0] gnt_o, pend_o;
  logic       busy_o, ovf_o, udf_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] cnt;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t sb_q[$];
  logic [7:0] exp_cnt;

  arbitro_contador #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .req_i(req_i), .dir_i(dir_i), .conta_o(conta_o), .gnt_o(gnt_o),
    .pend_o(pend_o), .busy_o(busy_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] c, input logic o, input logic u);
    exp_t e;
    e.gnt = g; e.cnt = c; e.ovf = o; e.udf = u;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every visible grant must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst_i && gnt_o != 4'b0000) begin
      act.gnt = gnt_o; act.cnt = conta_o; act.ovf = ovf_o; act.udf = udf_o;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got gnt=%b cnt=%0d expected no grant", gnt_o, conta_o);
      end else begin
        e = sb_q.pop_front();
        check("grant{gnt,cnt,ovf,udf}", {18'h0, act}, {18'h0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b1; clr_i = 1'b0; req_i = 4'b0011; dir_i = 4'b1111;
    #1;
    check("rst_conta", conta_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_pend", pend_o, 0);
    check("rst_flags", {ovf_o, udf_o, busy_o}, 0);
    tick(); tick();
    rst_i = 1'b0;
    repeat (5) tick();
    check("held_high_no_pend", pend_o, 0);
    check("held_high_conta", conta_o, 0);
    req_i = 4'b0010; tick();
    req_i = 4'b0011;
    push(4'b0001, 8'd1, 1'b0, 1'b0);
    tick();
    check("e0_pend", pend_o, 4'b0001);
    check("e0_no_gnt", gnt_o, 0);
    tick();
    check("e1_pend_clear", pend_o, 0);
    req_i = 4'b0000; tick();

    // All four rise together from ptr=0.
    rst_i = 1'b1; #1; rst_i = 1'b0;
    tick();
    req_i = 4'b1111; tick();
    check("all_pend", pend_o, 4'b1111);
    check("all_busy", busy_o, 1);
    push(4'b0001, 8'd1, 1'b0, 1'b0);
    push(4'b0010, 8'd2, 1'b0, 1'b0);
    push(4'b0100, 8'd3, 1'b0, 1'b0);
    push(4'b1000, 8'd4, 1'b0, 1'b0);
    repeat (4) tick();
    check("all_busy_fall", busy_o, 0);
    req_i = 4'b0000; tick();

    // Fairness: after granting 2, requester 3 beats requester 0.
    req_i = 4'b0100; tick();
    push(4'b0100, 8'd5, 1'b0, 1'b0);
    tick();
    req_i = 4'b1101;
    push(4'b1000, 8'd6, 1'b0, 1'b0);
    push(4'b0001, 8'd7, 1'b0, 1'b0);
    repeat (3) tick();
    check("fair_pend_empty", pend_o, 0);
    req_i = 4'b0000; tick();

    // Wrap: climb to 255, then overflow, then underflow, then clear.
    exp_cnt = 8'd7;
    for (int i = 0; i < 248; i++) begin
      exp_cnt = exp_cnt + 8'd1;
      push(4'b0001, exp_cnt, 1'b0, 1'b0);
      req_i = 4'b0001; tick();
      req_i = 4'b0000; tick();
    end
    check("preload_255", conta_o, 8'd255);
    push(4'b0001, 8'd0, 1'b1, 1'b0);
    req_i = 4'b0001; tick();
    req_i = 4'b0000; tick();
    check("ovf_set", ovf_o, 1);
    dir_i = 4'b0000;
    push(4'b0001, 8'd255, 1'b1, 1'b1);
    req_i = 4'b0001; tick();
    req_i = 4'b0000; tick();
    check("udf_set", udf_o, 1);
    clr_i = 1'b1; tick();
    clr_i = 1'b0;
    check("clr_conta", conta_o, 0);
    check("clr_flags", {ovf_o, udf_o}, 0);
    dir_i = 4'b1111;

    // Disabled: events accumulate, then drain in round-robin order from ptr=1.
    en_i = 1'b0;
    req_i = 4'b0111;
    repeat (3) tick();
    check("dis_pend", pend_o, 4'b0111);
    check("dis_conta", conta_o, 0);
    check("dis_no_gnt", gnt_o, 0);
    push(4'b0010, 8'd1, 1'b0, 1'b0);
    push(4'b0100, 8'd2, 1'b0, 1'b0);
    push(4'b0001, 8'd3, 1'b0, 1'b0);
    en_i = 1'b1;
    repeat (3) tick();
    check("dis_drained", pend_o, 0);
    req_i = 4'b0000; tick();

    // New event on requester 1 in the same cycle as its grant.
    en_i = 1'b0;
    req_i = 4'b0010; tick();
    req_i = 4'b0000; tick();
    en_i = 1'b1;
    req_i = 4'b0010;
    push(4'b0010, 8'd4, 1'b0, 1'b0);
    tick();
    check("same_cycle_pend_kept", pend_o, 4'b0010);
    push(4'b0010, 8'd5, 1'b0, 1'b0);
    tick();
    check("same_cycle_served", pend_o, 0);
    req_i = 4'b0000; tick();

    // Clear in the middle of a burst: no grant, pend retained.
    req_i = 4'b1111; tick();
    push(4'b0100, 8'd6, 1'b0, 1'b0);
    tick();
    clr_i = 1'b1; tick();
    clr_i = 1'b0;
    check("clr_burst_no_gnt", gnt_o, 0);
    check("clr_burst_pend", pend_o, 4'b1011);
    check("clr_burst_conta", conta_o, 0);
    push(4'b1000, 8'd1, 1'b0, 1'b0);
    push(4'b0001, 8'd2, 1'b0, 1'b0);
    push(4'b0010, 8'd3, 1'b0, 1'b0);
    repeat (3) tick();
    check("clr_burst_drained", pend_o, 0);

    // Asynchronous reset mid-burst.
    req_i = 4'b0000; tick();
    req_i = 4'b1111; tick();
    push(4'b0100, 8'd4, 1'b0, 1'b0);
    tick();
    @(negedge clk); #1;
    rst_i = 1'b1; #1;
    check("async_rst_conta", conta_o, 0);
    check("async_rst_gnt", gnt_o, 0);
    check("async_rst_pend", pend_o, 0);
    check("async_rst_busy", busy_o, 0);
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("post_rst_pend", pend_o, 0);
    check("post_rst_conta", conta_o, 0);
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
